// File: rtl/midi_pkg.sv
// Shared MIDI receive definitions: FSM state encoding and protocol constants.
// Imported by midi_uart_rx and by the future TX path.
package midi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int MIDI_BAUD       = 31250;
    localparam int MIDI_FRAME_BITS = 10;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input bit.
// Ports: clk, rst_n (async active-low), d_i (async in), q_o (synchronised out).
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI 8N1 serial receiver with a one-byte holding register read by busmaster.
// Ports: clk, reset (async active-low), rx (serial in), bus_rd (read strobe),
//        clr_err (clear sticky flags), data_o/data_oe (bus drive), irq,
//        frame_err, overrun (sticky status).
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       bus_rd,
    input  logic       clr_err,
    output logic [7:0] data_o,
    output logic       data_oe,
    output logic       irq,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          irq_q, irq_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          commit_q, commit_d;
    logic          ferr_set;
    logic          ovr_set;
    logic          rx_s;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(reset),
        .d_i  (rx),
        .q_o  (rx_s)
    );

    // Frame deserialiser
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        commit_d = 1'b0;
        ferr_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    timer_d = '0;
                end
            end
            START: begin
                if (timer_q == T_HALF) begin
                    timer_d = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    if (rx_s) begin
                        commit_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = WAIT_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register; a read coinciding with a commit hands over the
    // old byte on the bus while the new byte replaces it.
    always_comb begin
        hold_d  = hold_q;
        irq_d   = irq_q;
        ovr_set = 1'b0;
        if (commit_q) begin
            if (!irq_q) begin
                hold_d = shift_q;
                irq_d  = 1'b1;
            end else if (bus_rd) begin
                hold_d = shift_q;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (bus_rd) begin
            irq_d = 1'b0;
        end
        ferr_d = clr_err ? 1'b0 : (ferr_q | ferr_set);
        ovr_d  = clr_err ? 1'b0 : (ovr_q | ovr_set);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            idx_q    <= 3'd0;
            shift_q  <= 8'h00;
            hold_q   <= 8'h00;
            irq_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            hold_q   <= hold_d;
            irq_q    <= irq_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
            commit_q <= commit_d;
        end
    end

    // Bus strobe is ignored while held in reset.
    assign data_oe   = bus_rd & reset;
    assign data_o    = data_oe ? hold_q : 8'h00;
    assign irq       = irq_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_midi_uart_rx.sv
// Self-checking bench for midi_uart_rx: directed scenarios plus random frames
// compared against a byte-level behavioural model.
module tb_midi_uart_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       bus_rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data_o;
    logic       data_oe;
    logic       irq;
    logic       frame_err;
    logic       overrun;

    int errs = 0;
    int checks = 0;

    logic [7:0] hold_m = 8'h00;
    bit         irq_m = 1'b0;
    bit         ferr_m = 1'b0;
    bit         ovr_m = 1'b0;

    midi_uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .bus_rd   (bus_rd),
        .clr_err  (clr_err),
        .data_o   (data_o),
        .data_oe  (data_oe),
        .irq      (irq),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the line idle high.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input int brk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        repeat (brk) @(negedge clk);
        rx = 1'b1;
    endtask

    // Byte-level model of one completed frame with no read in flight.
    function automatic void model_frame(input logic [7:0] b, input bit ok);
        if (!ok) begin
            ferr_m = 1'b1;
        end else if (!irq_m) begin
            hold_m = b;
            irq_m  = 1'b1;
        end else begin
            ovr_m = 1'b1;
        end
    endfunction

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_irq"}, irq, irq_m);
        chk({tag, "_ferr"}, frame_err, ferr_m);
        chk({tag, "_ovr"}, overrun, ovr_m);
    endtask

    task automatic read_check(input string tag);
        bus_rd = 1'b1;
        #1;
        chk({tag, "_data"}, data_o, hold_m);
        chk({tag, "_oe"}, data_oe, 1'b1);
        @(negedge clk);
        bus_rd = 1'b0;
        irq_m  = 1'b0;
        #1;
        chk({tag, "_irqclr"}, irq, irq_m);
        chk({tag, "_idle"}, data_o, 8'h00);
    endtask

    task automatic clear_flags(input string tag);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        ferr_m  = 1'b0;
        ovr_m   = 1'b0;
        check_state(tag);
    endtask

    initial begin
        int lat;
        logic [7:0] b;
        bit ok;

        // Reset state, with bus_rd asserted to show it is ignored
        bus_rd = 1'b1;
        #12;
        chk("rst_data", data_o, 8'h00);
        chk("rst_oe", data_oe, 1'b0);
        check_state("rst");
        bus_rd = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        gap(3);

        // 1. Nominal with latency measurement
        lat = -1;
        fork
            send_frame(8'h90, 1'b1, 0);
            begin
                for (int k = 1; k <= 120; k++) begin
                    @(negedge clk);
                    if (irq && lat < 0) lat = k;
                end
            end
        join
        model_frame(8'h90, 1'b1);
        chk("t1_latency", (lat >= 78 && lat <= 80), 1'b1);
        if (lat < 0) $display("FAIL t1_timeout: got no irq expected irq");
        check_state("t1");
        read_check("t1_rd");

        // 2. Start-bit glitch
        rx = 1'b0;
        gap(2);
        rx = 1'b1;
        gap(12);
        check_state("t2_glitch");
        send_frame(8'h3C, 1'b1, 0);
        gap(3);
        model_frame(8'h3C, 1'b1);
        check_state("t2");
        read_check("t2_rd");

        // 3. Framing error followed by a good frame
        send_frame(8'h45, 1'b0, 20);
        gap(3);
        model_frame(8'h45, 1'b0);
        check_state("t3_bad");
        send_frame(8'h3C, 1'b1, 0);
        gap(3);
        model_frame(8'h3C, 1'b1);
        check_state("t3_good");
        read_check("t3_rd");
        clear_flags("t3_clr");

        // 4. Overrun
        send_frame(8'h11, 1'b1, 0);
        gap(3);
        model_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1, 0);
        gap(3);
        model_frame(8'h22, 1'b1);
        check_state("t4");
        read_check("t4_rd");
        clear_flags("t4_clr");

        // stale read with nothing pending
        read_check("stale_rd");

        // 5. Read coinciding with commit
        send_frame(8'hAA, 1'b1, 0);
        gap(3);
        model_frame(8'hAA, 1'b1);
        check_state("t5_pre");
        fork
            send_frame(8'h55, 1'b1, 0);
            begin
                repeat (79) @(negedge clk);
                bus_rd = 1'b1;
                #1;
                chk("t5_old", data_o, 8'hAA);
                @(negedge clk);
                bus_rd = 1'b0;
            end
        join
        hold_m = 8'h55;
        gap(2);
        check_state("t5");
        read_check("t5_rd");

        // 6. Reset during data bit 3
        fork
            send_frame(8'hF0, 1'b1, 0);
            begin
                repeat (36) @(negedge clk);
                reset  = 1'b0;
                bus_rd = 1'b1;
                #1;
                chk("t6_data", data_o, 8'h00);
                chk("t6_oe", data_oe, 1'b0);
                chk("t6_irq", irq, 1'b0);
                chk("t6_ferr", frame_err, 1'b0);
                chk("t6_ovr", overrun, 1'b0);
                bus_rd = 1'b0;
            end
        join
        hold_m = 8'h00;
        irq_m  = 1'b0;
        ferr_m = 1'b0;
        ovr_m  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        gap(3);
        send_frame(8'h7F, 1'b1, 0);
        gap(3);
        model_frame(8'h7F, 1'b1);
        check_state("t6");
        read_check("t6_rd");

        // Random frames against the model
        for (int n = 0; n < 40; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            send_frame(b, ok, ok ? 0 : int'($urandom_range(0, 15)));
            gap(int'($urandom_range(2, 6)));
            model_frame(b, ok);
            check_state("rnd");
            if ($urandom_range(0, 2) != 0) read_check("rnd_rd");
            if ($urandom_range(0, 4) == 0) clear_flags("rnd_clr");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/midi_uart_rx.md
Name: midi_uart_rx

Overview:
MIDI serial receiver, one instance per input port. It sits directly upstream of busmaster. It deserialises 31.25 kbaud 8N1 frames from an rx pin into a one-byte holding register and raises irq to busmaster. When busmaster pulses bus_rd, the block drives the held byte onto the shared 8-bit data bus. Four instances feed busmaster irq[3:0] and bus_rd[3:0].

Parameters:
CLKS_PER_BIT, 32, clk cycles per MIDI bit (CLK_HZ / 31250); must be even and >= 4.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset (0 = reset).
rx  in  1  serial MIDI input (asynchronous to clk; idle high).
bus_rd  in  1  read strobe from busmaster, one clk cycle wide.
clr_err  in  1  synchronous clear of frame_err and overrun.
data_o  out  8  held byte while bus_rd=1; 8'h00 otherwise.
data_oe  out  1  equals bus_rd; busmaster muxes the bus on it.
irq  out  1  holding register full.
frame_err  out  1  sticky: stop bit sampled low.
overrun  out  1  sticky: byte completed while holding register full.

Behaviour:
- Reset (reset=0, async): FSM=IDLE, counters=0, shift/hold=8'h00, synchroniser=2'b11. irq, frame_err and overrun are 0. data_o=0 and data_oe=0 because bus_rd is ignored until reset is released.
- rx passes through a 2-flop synchroniser (rx_s); all sampling uses rx_s.
- Bit timer counts 0..CLKS_PER_BIT-1; bit index counts 0..7.
- FSM:
  - IDLE: rx_s==0 -> START, timer=0.
  - START: at timer==CLKS_PER_BIT/2-1, sample rx_s. If 1 (glitch) -> IDLE. If 0 -> DATA, timer=0, idx=0.
  - DATA: at timer==CLKS_PER_BIT-1, shift rx_s in LSB-first. idx==7 -> STOP, else idx++.
  - STOP: at timer==CLKS_PER_BIT-1, sample rx_s. If 1 -> commit, then IDLE. If 0 -> frame_err<=1, byte discarded, -> WAIT_IDLE.
  - WAIT_IDLE (break/garbage): stay until rx_s==1, then -> IDLE.
- Commit takes effect on the clock edge after the stop sample:
  - irq==0: hold<=shift, irq<=1.
  - irq==1 and bus_rd==0: new byte dropped, hold unchanged, overrun<=1.
  - irq==1 and bus_rd==1 in the commit cycle: data_o returns the old byte, hold<=new byte, irq stays 1, no overrun.
- Read: data_o = bus_rd ? hold : 8'h00 (combinational). irq clears on the edge where bus_rd=1, unless a commit occurs in the same cycle.
- bus_rd while irq==0: data_o shows the stale hold value; no state change.
- clr_err=1: frame_err and overrun go to 0 next edge. clr_err has priority over setting either flag in the same cycle.
- Latency: irq rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks (±1) after rx falls at the start bit.
- Reset mid-frame aborts the partial byte; the next full frame after release is received normally.

Decomposition:
- Package midi_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, WAIT_IDLE}
  - MIDI_BAUD=31250
  - MIDI_FRAME_BITS=10
- Sub-module sync_2ff: generic 2-flop synchroniser with reset value parameter. busmaster and the future TX path reuse it.
- Bit timer, FSM and holding register stay in midi_uart_rx.

Test Plan:
All tests use CLKS_PER_BIT=8.
1. Nominal: drive frame 0x90 (start, bits LSB-first, stop) -> irq=1 at 2+4+72+1 clocks ±1; bus_rd pulse -> data_o=8'h90, data_oe=1; irq=0 next edge.
2. Glitch: rx low for 2 clocks, then high -> no irq, FSM back to IDLE; a following 0x3C frame is received correctly.
3. Framing: frame 0x45 with stop bit 0, rx held low 20 clocks, then high -> frame_err=1, irq=0; next frame 0x3C -> irq=1, data 8'h3C; clr_err -> frame_err=0.
4. Overrun: frames 0x11 then 0x22 with no read -> overrun=1; read returns 8'h11, irq=0; clr_err -> overrun=0.
5. Simultaneous: hold 0xAA with irq=1; pulse bus_rd exactly in the commit cycle of frame 0x55 -> data_o=8'hAA, irq stays 1, overrun=0; next read returns 8'h55.
6. Reset mid-frame: reset=0 during data bit 3 of frame 0xF0 -> irq, flags and data_o are 0 immediately; after release, frame 0x7F -> irq=1, data 8'h7F.
